z80_int_ctrl: RTL and testbench

Vectored interrupt controller for the Z80 core. It sits beside `memory` and `ports` on the shared address/data bus. It collects up to N_SRC edge-triggered peripheral interrupt requests, applies a mask and nested in-service priority, and drives INT_L. During the Z80 interrupt-acknowledge cycle it supplies an IM2 vector byte. Mask, status and end-of-interrupt are reached through Z80 I/O ports.

---
 rtl/z80_ic_pkg.sv | 26 ++
 rtl/z80_ic_prio.sv | 22 ++
 rtl/z80_int_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_ic_pkg.sv
// rtl/z80_ic_pkg.sv - shared types, port defaults and vector helpers for the Z80 interrupt controller
package z80_ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        IO   = 2'd2
    } ic_state_t;

    localparam int         DEF_N_SRC     = 8;
    localparam logic [7:0] DEF_VEC_BASE  = 8'h00;
    localparam logic [7:0] DEF_MASK_PORT = 8'hE0;
    localparam logic [7:0] DEF_EOI_PORT  = 8'hE1;
    localparam logic [7:0] DEF_STAT_PORT = 8'hE2;

    // Offset of the spurious vector: the slot just past the last real source.
    function automatic logic [7:0] spurious_offset(input int n_src);
        return 8'(n_src * 2);
    endfunction

    // IM2 vector for a source index; two bytes per table entry, 8-bit wrap.
    function automatic logic [7:0] vector_of(input logic [7:0] base, input logic [7:0] idx);
        return base + {idx[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/z80_ic_prio.sv
// rtl/z80_ic_prio.sv - combinational lowest-index-wins priority encoder
module z80_ic_prio #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/z80_int_ctrl.sv
// rtl/z80_int_ctrl.sv - vectored IM2 interrupt controller with mask, nesting and EOI over Z80 I/O ports
module z80_int_ctrl
    import z80_ic_pkg::*;
#(
    parameter int         N_SRC     = DEF_N_SRC,
    parameter logic [7:0] VEC_BASE  = DEF_VEC_BASE,
    parameter logic [7:0] MASK_PORT = DEF_MASK_PORT,
    parameter logic [7:0] EOI_PORT  = DEF_EOI_PORT,
    parameter logic [7:0] STAT_PORT = DEF_STAT_PORT
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic [N_SRC-1:0] irq,
    input  logic [7:0]       addr_lo,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             data_oe,
    input  logic             M1_L,
    input  logic             IORQ_L,
    input  logic             RD_L,
    input  logic             WR_L,
    output logic             INT_L
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    ic_state_t        state;
    ic_state_t        state_nxt;

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] in_service;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] in_service_nxt;

    logic             ack_valid;
    logic [IW-1:0]    ack_idx;

    logic [N_SRC-1:0] limit;
    logic [N_SRC-1:0] eligible;
    logic             win;
    logic [IW-1:0]    win_idx;
    logic             is_valid;
    logic [IW-1:0]    is_idx;

    logic [7:0]       mask_ext;
    logic [7:0]       pend_ext;

    logic             ack_cyc;
    logic             io_cyc;
    logic             io_wr;
    logic             hit_mask;
    logic             hit_eoi;
    logic             hit_stat;
    logic             port_hit;

    logic             oe_nxt;
    logic [7:0]       dout_nxt;
    logic             mask_we;
    logic             eoi_do;
    logic             ack_take;
    logic             ack_rel;

    // Bus cycle decode; a write strobe takes precedence if both strobes are low.
    always_comb begin
        ack_cyc  = !M1_L && !IORQ_L;
        io_cyc   = M1_L && !IORQ_L && (!RD_L || !WR_L);
        io_wr    = !WR_L;
        hit_mask = (addr_lo == MASK_PORT);
        hit_eoi  = (addr_lo == EOI_PORT);
        hit_stat = (addr_lo == STAT_PORT);
        port_hit = hit_mask || hit_eoi || hit_stat;
    end

    // Lowest in-service source, used both to fence eligibility and to pick the EOI target.
    z80_ic_prio #(.W(N_SRC), .IW(IW)) u_is_prio (
        .req   (in_service),
        .valid (is_valid),
        .idx   (is_idx)
    );

    // Only sources strictly more urgent than the one being serviced may interrupt.
    always_comb begin
        limit = '1;
        if (is_valid) begin
            for (int i = 0; i < N_SRC; i++) begin
                limit[i] = (IW'(i) < is_idx);
            end
        end
        eligible = pending & ~mask & limit;
    end

    z80_ic_prio #(.W(N_SRC), .IW(IW)) u_win_prio (
        .req   (eligible),
        .valid (win),
        .idx   (win_idx)
    );

    // Zero-extended register images for port reads.
    always_comb begin
        mask_ext               = '0;
        pend_ext               = '0;
        mask_ext[N_SRC-1:0]    = mask;
        pend_ext[N_SRC-1:0]    = pending;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: enter on an ack or a decoded port access, leave when IORQ_L releases.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ack_cyc) begin
                    state_nxt = ACK;
                end else if (io_cyc && port_hit) begin
                    state_nxt = IO;
                end
            end
            ACK: if (IORQ_L) state_nxt = IDLE;
            IO:  if (IORQ_L) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: bus drive values and one-shot register actions taken on entry/exit.
    always_comb begin
        oe_nxt   = data_oe;
        dout_nxt = data_out;
        mask_we  = 1'b0;
        eoi_do   = 1'b0;
        ack_take = 1'b0;
        ack_rel  = 1'b0;
        case (state)
            IDLE: begin
                oe_nxt = 1'b0;
                if (ack_cyc) begin
                    ack_take = 1'b1;
                    oe_nxt   = 1'b1;
                    dout_nxt = win ? vector_of(VEC_BASE, 8'(win_idx))
                                   : VEC_BASE + spurious_offset(N_SRC);
                end else if (io_cyc && port_hit) begin
                    if (io_wr) begin
                        mask_we = hit_mask;
                        eoi_do  = hit_eoi;
                    end else if (hit_mask) begin
                        oe_nxt   = 1'b1;
                        dout_nxt = mask_ext;
                    end else if (hit_stat) begin
                        oe_nxt   = 1'b1;
                        dout_nxt = pend_ext;
                    end
                end
            end
            ACK: begin
                if (IORQ_L) begin
                    oe_nxt   = 1'b0;
                    dout_nxt = 8'h00;
                    ack_rel  = 1'b1;
                end
            end
            IO: begin
                if (IORQ_L) begin
                    oe_nxt   = 1'b0;
                    dout_nxt = 8'h00;
                end
            end
            default: begin
                oe_nxt   = 1'b0;
                dout_nxt = 8'h00;
            end
        endcase
    end

    // Next pending/in-service: a fresh edge beats a same-cycle clear, EOI drops the innermost level.
    always_comb begin
        pending_nxt    = pending;
        in_service_nxt = in_service;
        if (ack_rel && ack_valid) begin
            pending_nxt[ack_idx]    = 1'b0;
            in_service_nxt[ack_idx] = 1'b1;
        end
        if (eoi_do && is_valid) begin
            in_service_nxt[is_idx] = 1'b0;
        end
        pending_nxt = pending_nxt | (irq & ~irq_q);
    end

    // Datapath registers and the registered INT_L / bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '1;
            in_service <= '0;
            ack_valid  <= 1'b0;
            ack_idx    <= '0;
            data_oe    <= 1'b0;
            data_out   <= 8'h00;
            INT_L      <= 1'b1;
        end else begin
            irq_q      <= irq;
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            data_oe    <= oe_nxt;
            data_out   <= dout_nxt;
            INT_L      <= (state == ACK) ? 1'b1 : ~win;
            if (mask_we) begin
                mask <= data_in[N_SRC-1:0];
            end
            if (ack_take) begin
                ack_valid <= win;
                ack_idx   <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// tb/tb_z80_int_ctrl.sv - randomized scoreboard bench for z80_int_ctrl against a behavioural model
module tb_z80_int_ctrl;

    logic       clk;
    logic       rst_L;
    logic [7:0] irq;
    logic [7:0] addr_lo;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       M1_L, IORQ_L, RD_L, WR_L;
    logic       INT_L;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    logic [7:0] m_mask;
    logic [7:0] m_pend;
    logic [7:0] m_isr;

    z80_int_ctrl dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .irq      (irq),
        .addr_lo  (addr_lo),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .M1_L     (M1_L),
        .IORQ_L   (IORQ_L),
        .RD_L     (RD_L),
        .WR_L     (WR_L),
        .INT_L    (INT_L)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every time the block starts driving the bus, pop the expected byte.
    initial begin
        logic oe_prev;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (data_oe && !oe_prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL bus_byte: got %02h with data_oe but expected no drive", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        n_bad++;
                        $display("FAIL bus_byte: got %02h expected %02h", data_out, e);
                    end
                end
            end
            oe_prev = data_oe;
        end
    end

    // Highest-priority eligible source from the rules: unmasked, pending, above the innermost active level.
    function automatic int model_win();
        int lo_is;
        lo_is = 8;
        for (int i = 7; i >= 0; i--) if (m_isr[i]) lo_is = i;
        for (int i = 0; i < lo_is; i++) if (m_pend[i] && !m_mask[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mask = 8'hFF;
        m_pend = 8'h00;
        m_isr  = 8'h00;
    endtask

    task automatic bus_idle();
        M1_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1;
        addr_lo = 8'h00; data_in = 8'h00;
    endtask

    task automatic check_state(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "/INT_L"},      32'(INT_L),          32'(model_win() < 0));
        check({tag, "/pending"},    32'(dut.pending),    32'(m_pend));
        check({tag, "/in_service"}, 32'(dut.in_service), 32'(m_isr));
        check({tag, "/mask"},       32'(dut.mask),       32'(m_mask));
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        @(negedge clk);
        irq = bits;
        @(negedge clk);
        irq = 8'h00;
        m_pend = m_pend | bits;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr_lo = a; data_in = d; IORQ_L = 1'b0; WR_L = 1'b0;
        repeat (3) @(negedge clk);
        bus_idle();
        if (a == 8'hE0) m_mask = d;
        if (a == 8'hE1) begin
            for (int i = 0; i < 8; i++) begin
                if (m_isr[i]) begin
                    m_isr[i] = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic io_read(input logic [7:0] a);
        if (a == 8'hE0) exp_q.push_back(m_mask);
        if (a == 8'hE2) exp_q.push_back(m_pend);
        @(negedge clk);
        addr_lo = a; IORQ_L = 1'b0; RD_L = 1'b0;
        repeat (3) @(negedge clk);
        bus_idle();
    endtask

    task automatic z80_ack(input int edge_at);
        int w;
        w = model_win();
        exp_q.push_back((w >= 0) ? 8'(2 * w) : 8'h10);
        @(negedge clk);
        M1_L = 1'b0; IORQ_L = 1'b0;
        repeat (3) @(negedge clk);
        M1_L = 1'b1; IORQ_L = 1'b1;
        if (edge_at >= 0) irq[edge_at] = 1'b1;
        @(negedge clk);
        irq = 8'h00;
        if (w >= 0) begin
            m_pend[w] = 1'b0;
            m_isr[w]  = 1'b1;
        end
        if (edge_at >= 0) m_pend[edge_at] = 1'b1;
    endtask

    initial begin
        irq = 8'h00;
        bus_idle();
        model_reset();
        rst_L = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;

        // Reset values
        check("rst/INT_L",    32'(INT_L),    32'h1);
        check("rst/data_oe",  32'(data_oe),  32'h0);
        check("rst/data_out", 32'(data_out), 32'h00);
        check_state("rst");

        // Basic request, timing and vector for source 0
        io_write(8'hE0, 8'hFE);
        check_state("mask_fe");
        pulse_irq(8'h01);
        check("req0/INT_L_lag", 32'(INT_L), 32'h1);
        @(negedge clk);
        check("req0/INT_L_low", 32'(INT_L), 32'h0);
        z80_ack(-1);
        check_state("ack0");
        io_write(8'hE1, 8'h00);
        check_state("eoi0");

        // Masked request is latched and visible in status, then released by unmasking
        io_write(8'hE0, 8'hFF);
        pulse_irq(8'h08);
        check_state("masked3");
        io_read(8'hE2);
        io_read(8'hE0);
        io_write(8'hE0, 8'h00);
        check_state("unmask3");
        z80_ack(-1);
        check_state("ack3");

        // Nesting: lower priority waits, higher priority preempts
        pulse_irq(8'h20);
        check_state("nest5_blocked");
        pulse_irq(8'h02);
        check_state("nest1_pre");
        z80_ack(-1);
        check_state("nest1_ack");
        io_write(8'hE1, 8'h5A);
        check_state("nest_eoi1");
        io_write(8'hE1, 8'h00);
        check_state("nest_eoi2");
        z80_ack(-1);
        io_write(8'hE1, 8'h00);
        check_state("nest5_done");

        // Spurious ack and EOI with nothing in service
        z80_ack(-1);
        check_state("spurious");
        io_write(8'hE1, 8'h00);
        check_state("eoi_empty");

        // Edge on the same cycle the ack releases
        pulse_irq(8'h04);
        z80_ack(2);
        check_state("same_cycle");
        io_write(8'hE1, 8'h00);
        check_state("same_cycle_eoi");
        z80_ack(-1);
        io_write(8'hE1, 8'h00);
        check_state("same_cycle_done");

        // Randomized mix of requests, masks, acks, EOIs and stray port accesses
        for (int n = 0; n < 70; n++) begin
            int op;
            op = $urandom_range(0, 7);
            case (op)
                0, 1: pulse_irq(8'($urandom_range(1, 255)));
                2:    io_write(8'hE0, 8'($urandom & $urandom));
                3, 4: z80_ack(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
                5:    io_write(8'hE1, 8'($urandom));
                6:    io_read(($urandom_range(0, 1) == 0) ? 8'hE2 : 8'hE0);
                default: begin
                    if ($urandom_range(0, 1) == 0) io_write(8'($urandom_range(8'h10, 8'hDF)), 8'($urandom));
                    else io_read(8'($urandom_range(8'h10, 8'hDF)));
                end
            endcase
            check_state("rand");
        end

        // Reset while the vector is on the bus
        io_write(8'hE0, 8'h00);
        pulse_irq(8'h01);
        check_state("pre_rst");
        exp_q.push_back(8'h00);
        @(negedge clk);
        M1_L = 1'b0; IORQ_L = 1'b0;
        @(negedge clk);
        rst_L = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_ack/data_oe", 32'(data_oe),  32'h0);
        check("rst_ack/INT_L",   32'(INT_L),    32'h1);
        check("rst_ack/mask",    32'(dut.mask), 32'hFF);
        check("rst_ack/pending", 32'(dut.pending), 32'h00);
        rst_L = 1'b1;
        bus_idle();
        check_state("post_rst");

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d bytes left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
